// File: rtl/fifo8x9_ctrl_if.sv
// Producer/consumer handshake bundle for fifo8x9_ctrl.
//   flush   : synchronous flush command, level-sensitive
//   wr_req  : producer asks to push this cycle
//   wr_ack  : push accepted this cycle
//   rd_req  : consumer asks to pop this cycle
//   rd_ack  : pop accepted; storage DataOut valid this cycle
// master : the requesting side (producer/consumer/flush source)
// slave  : the controller
interface fifo8x9_ctrl_if;
  logic flush;
  logic wr_req;
  logic wr_ack;
  logic rd_req;
  logic rd_ack;

  modport master (
    output flush,
    output wr_req,
    output rd_req,
    input  wr_ack,
    input  rd_ack
  );

  modport slave (
    input  flush,
    input  wr_req,
    input  rd_req,
    output wr_ack,
    output rd_ack
  );
endinterface

// File: rtl/fifo8x9_ctrl.sv
// Sequencing controller for the 8-entry x 9-bit FIFO storage block.
// Drives the storage pointer clears, increments and read/write enables, tracks
// occupancy, decodes level flags and keeps sticky overflow/underflow errors.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   bus (slave)       : flush, wr_req/wr_ack, rd_req/rd_ack handshakes
//   rd_ptr_clr, wr_ptr_clr, rd_inc, wr_inc, rden, wren : storage strobes
//   count             : occupancy 0..DEPTH
//   full, empty, almost_full, almost_empty : decoded from count register
//   overflow, underflow : sticky errors, cleared by flush or reset
//   busy              : high in INIT or FLUSH, no transfers accepted
module fifo8x9_ctrl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = 4,
  parameter int unsigned AF_LEVEL = 6,
  parameter int unsigned AE_LEVEL = 2
) (
  input  logic               clk,
  input  logic               rst,
  fifo8x9_ctrl_if.slave      bus,
  output logic               rd_ptr_clr,
  output logic               wr_ptr_clr,
  output logic               rd_inc,
  output logic               wr_inc,
  output logic               rden,
  output logic               wren,
  output logic [CNT_W-1:0]   count,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow,
  output logic               busy
);

  localparam logic [CNT_W-1:0] DepthC = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AfC    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AeC    = CNT_W'(AE_LEVEL);

  typedef enum logic [1:0] {StInit, StRun, StFlush} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             in_run;
  logic             push;
  logic             pop;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:  state_d = bus.flush ? StFlush : StRun;
      StRun:   if (bus.flush) state_d = StFlush;
      StFlush: if (!bus.flush) state_d = StRun;
      default: state_d = StInit;
    endcase
  end

  // Output logic
  always_comb begin
    in_run     = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    rd_ptr_clr = 1'b0;
    wr_ptr_clr = 1'b0;
    busy       = 1'b1;
    unique case (state_q)
      StInit: begin
        // State sits in INIT throughout reset; the clear pulse belongs only to
        // the first cycle after release, so gate it with rst.
        rd_ptr_clr = rst;
        wr_ptr_clr = rst;
      end
      StRun: begin
        busy   = 1'b0;
        // Flush wins over any transfer requested in the same cycle.
        in_run = ~bus.flush;
        push   = in_run & bus.wr_req & ~full;
        pop    = in_run & bus.rd_req & ~empty;
      end
      StFlush: begin
        rd_ptr_clr = 1'b1;
        wr_ptr_clr = 1'b1;
      end
      default: ;
    endcase
    bus.wr_ack = push;
    wren       = push;
    wr_inc     = push;
    bus.rd_ack = pop;
    rden       = pop;
    rd_inc     = pop;
  end

  // Occupancy and sticky error next-state
  always_comb begin
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (state_q == StFlush) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (in_run) begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      overflow_d  = overflow_q | (bus.wr_req & full);
      underflow_d = underflow_q | (bus.rd_req & empty);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Flags decode the registered count only, so they lag the accepting edge.
  always_comb begin
    count        = count_q;
    full         = (count_q == DepthC);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AfC);
    almost_empty = (count_q <= AeC);
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Scoreboard bench for fifo8x9_ctrl with a behavioural storage block attached.
module tb_fifo8x9_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rd_ptr_clr, wr_ptr_clr, rd_inc, wr_inc, rden, wren;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow, busy;

  fifo8x9_ctrl_if bus ();

  fifo8x9_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .rd_ptr_clr   (rd_ptr_clr),
    .wr_ptr_clr   (wr_ptr_clr),
    .rd_inc       (rd_inc),
    .wr_inc       (wr_inc),
    .rden         (rden),
    .wren         (wren),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Storage block model driven by the controller strobes
  logic [8:0] mem [8];
  logic [2:0] wp = 3'd0;
  logic [2:0] rp = 3'd0;
  logic [8:0] wr_data = 9'd0;
  wire  [8:0] data_out = rden ? mem[rp] : 9'bz;

  always @(posedge clk) begin
    if (wren) mem[wp] <= wr_data;
    if (wr_ptr_clr) wp <= 3'd0;
    else if (wr_inc) wp <= wp + 3'd1;
    if (rd_ptr_clr) rp <= 3'd0;
    else if (rd_inc) rp <= rp + 3'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        wr_ack, rd_ack, clr, busy;
    logic        full, empty, af, ae, ovf, unf;
    logic [8:0]  rdata;
    int unsigned cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  // Reference model: 0 = init, 1 = run, 2 = flush
  int         st = 0;
  logic [8:0] ref_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  // Drive one cycle, queue its expected response, then advance the model.
  task automatic cycle(input logic w, input logic r, input logic f, input logic [8:0] d);
    exp_t e;
    int   sz;
    logic push, pop;
    bus.wr_req = w;
    bus.rd_req = r;
    bus.flush  = f;
    wr_data    = d;
    sz   = ref_q.size();
    push = (st == 1) && !f && w && (sz < 8);
    pop  = (st == 1) && !f && r && (sz > 0);
    e.wr_ack = push;
    e.rd_ack = pop;
    e.rdata  = pop ? ref_q[0] : 9'bz;
    e.cnt    = sz;
    e.full   = (sz == 8);
    e.empty  = (sz == 0);
    e.af     = (sz >= 6);
    e.ae     = (sz <= 2);
    e.ovf    = m_ovf;
    e.unf    = m_unf;
    e.busy   = (st != 1);
    e.clr    = (st != 1);
    exp_q.push_back(e);
    case (st)
      0: st = f ? 2 : 1;
      1: begin
        if (f) st = 2;
        else begin
          if (w && sz == 8) m_ovf = 1'b1;
          if (r && sz == 0) m_unf = 1'b1;
          if (pop) void'(ref_q.pop_front());
          if (push) ref_q.push_back(d);
        end
      end
      default: begin
        ref_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        st = f ? 2 : 1;
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares whenever an expectation is pending, mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("wr_ack", bus.wr_ack, mon_e.wr_ack);
      chk("wren", wren, mon_e.wr_ack);
      chk("wr_inc", wr_inc, mon_e.wr_ack);
      chk("rd_ack", bus.rd_ack, mon_e.rd_ack);
      chk("rden", rden, mon_e.rd_ack);
      chk("rd_inc", rd_inc, mon_e.rd_ack);
      chk("rd_ptr_clr", rd_ptr_clr, mon_e.clr);
      chk("wr_ptr_clr", wr_ptr_clr, mon_e.clr);
      chk("busy", busy, mon_e.busy);
      chk("count", count, mon_e.cnt);
      chk("full", full, mon_e.full);
      chk("empty", empty, mon_e.empty);
      chk("almost_full", almost_full, mon_e.af);
      chk("almost_empty", almost_empty, mon_e.ae);
      chk("overflow", overflow, mon_e.ovf);
      chk("underflow", underflow, mon_e.unf);
      chk("data_out", data_out, mon_e.rdata);
    end
  end

  task automatic chk_reset_state();
    chk("rst count", count, 0);
    chk("rst empty", empty, 1);
    chk("rst almost_empty", almost_empty, 1);
    chk("rst full", full, 0);
    chk("rst almost_full", almost_full, 0);
    chk("rst busy", busy, 1);
    chk("rst overflow", overflow, 0);
    chk("rst underflow", underflow, 0);
    chk("rst strobes", {rd_ptr_clr, wr_ptr_clr, rd_inc, wr_inc, rden, wren}, 0);
    chk("rst acks", {bus.wr_ack, bus.rd_ack}, 0);
  endtask

  initial begin
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.flush  = 1'b0;
    #3;
    chk_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // INIT clear pulse, then fill past full
    cycle(1'b0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 1'b0, 9'(9'h101 + i));
    cycle(1'b0, 1'b0, 1'b0, 9'd0);
    // Drain past empty
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b0, 9'd0);
    cycle(1'b0, 1'b0, 1'b0, 9'd0);

    // Concurrent push/pop at count 4, then at full
    while (ref_q.size() < 4) cycle(1'b1, 1'b0, 1'b0, 9'($urandom_range(0, 511)));
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 9'($urandom_range(0, 511)));
    while (ref_q.size() < 8) cycle(1'b1, 1'b0, 1'b0, 9'($urandom_range(0, 511)));
    cycle(1'b1, 1'b1, 1'b0, 9'($urandom_range(0, 511)));
    cycle(1'b0, 1'b0, 1'b0, 9'd0);

    // Flush at count 5 with wr_req held
    while (ref_q.size() > 5) cycle(1'b0, 1'b1, 1'b0, 9'd0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 9'($urandom_range(0, 511)));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 9'($urandom_range(0, 511)));

    // Randomised traffic with alternating fill/drain bias and rare flushes
    for (int i = 0; i < 400; i++) begin
      int   wp_pct;
      logic w, r, f;
      wp_pct = ((i % 80) < 40) ? 70 : 30;
      w = ($urandom_range(0, 99) < wp_pct);
      r = ($urandom_range(0, 99) < (100 - wp_pct));
      f = ($urandom_range(0, 47) == 0);
      cycle(w, r, f, 9'($urandom_range(0, 511)));
    end

    // Asynchronous reset mid-burst at count 3
    cycle(1'b0, 1'b0, 1'b0, 9'd0);
    cycle(1'b0, 1'b0, 1'b0, 9'd0);
    while (ref_q.size() < 3) cycle(1'b1, 1'b0, 1'b0, 9'($urandom_range(0, 511)));
    while (ref_q.size() > 3) cycle(1'b0, 1'b1, 1'b0, 9'd0);
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    chk_reset_state();
    ref_q.delete();
    st    = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 9'd0);
    cycle(1'b1, 1'b0, 1'b0, 9'h0a5);
    cycle(1'b1, 1'b0, 1'b0, 9'h15a);
    cycle(1'b0, 1'b1, 1'b0, 9'd0);
    cycle(1'b0, 1'b1, 1'b0, 9'd0);
    cycle(1'b0, 1'b0, 1'b0, 9'd0);

    @(negedge clk);
    #1;
    chk("scoreboard drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
